// File: rtl/acc_cpu_pkg.sv
// acc_cpu_pkg: shared types for the accumulator CPU core.
//   opcodeT  - 4-bit instruction opcodes
//   stateT   - control FSM states
//   iw()     - instruction width for a given data width (opcode + operand)
package acc_cpu_pkg;

   typedef enum logic [3:0] {
      OP_NOP  = 4'h0,
      OP_LDI  = 4'h1,
      OP_LD   = 4'h2,
      OP_ST   = 4'h3,
      OP_ADDI = 4'h4,
      OP_ADD  = 4'h5,
      OP_SUBI = 4'h6,
      OP_SUB  = 4'h7,
      OP_AND  = 4'h8,
      OP_OR   = 4'h9,
      OP_XOR  = 4'hA,
      OP_JMP  = 4'hB,
      OP_JZ   = 4'hC,
      OP_JC   = 4'hD,
      OP_OUT  = 4'hE,
      OP_HLT  = 4'hF
   } opcodeT;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_EXEC,
      ST_MEMRD,
      ST_OUTW,
      ST_HALT
   } stateT;

   function automatic int iw(input int dw);
      return dw + 4;
   endfunction

endpackage

// File: rtl/acc_cpu_alu.sv
// acc_cpu_alu: combinational ALU for the accumulator core.
// Ports:
//   opcode   in  4   current instruction opcode
//   a        in  DW  accumulator
//   b        in  DW  immediate or RAM operand
//   carryIn  in  1   current carry flag
//   result   out DW  new accumulator value (a when the op does not write acc)
//   carryOut out 1   new carry flag
//   zero     out 1   result == 0
module acc_cpu_alu
   import acc_cpu_pkg::*;
#(
   parameter int DW = 4
) (
   input  opcodeT          opcode,
   input  logic [DW-1:0]   a,
   input  logic [DW-1:0]   b,
   input  logic            carryIn,
   output logic [DW-1:0]   result,
   output logic            carryOut,
   output logic            zero
);

   always_comb begin
      result   = a;
      carryOut = carryIn;
      case (opcode)
         OP_LDI, OP_LD:   result = b;
         OP_ADDI, OP_ADD: {carryOut, result} = {1'b0, a} + {1'b0, b};
         OP_SUBI, OP_SUB: begin
            result   = a - b;
            // carry means "no borrow"
            carryOut = (a >= b);
         end
         OP_AND:          result = a & b;
         OP_OR:           result = a | b;
         OP_XOR:          result = a ^ b;
         default:         ;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/acc_cpu_core.sv
// acc_cpu_core: multi-cycle accumulator CPU with internal data RAM,
// external combinational program memory and a valid/ready output port.
// Optional macro ACC_CPU_SINGLE_STEP_EN adds a 'step' input: each
// instruction starts only on run&&step and always returns to IDLE.
// Ports:
//   clk, rst_n          clock / async active-low reset
//   run                 1 = execute, 0 = stop at next instruction boundary
//   step                (ACC_CPU_SINGLE_STEP_EN only) single-step strobe
//   imem_addr/imem_data program memory address (=PC) / instruction
//   out_data/valid/ready output port, value captured by OUT
//   acc_o, pc_o, carry_o, zero_o, halted  architectural state view
//
// state | meaning
// IDLE  | waiting for run (and step) to start an instruction
// FETCH | IR <= imem_data, PC <= PC+1
// EXEC  | decode; single-cycle ops complete, RAM read address applied
// MEMRD | RAM read data valid; RAM-operand op completes
// OUTW  | out_valid held until out_ready
// HALT  | stopped until reset
module acc_cpu_core
   import acc_cpu_pkg::*;
#(
   parameter  int DW  = 4,
   parameter  int AW  = 4,   // must be <= DW
   parameter  int PAW = 4,   // must be <= DW
   localparam int IW  = iw(DW)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            run,
`ifdef ACC_CPU_SINGLE_STEP_EN
   input  logic            step,
`endif
   output logic [PAW-1:0]  imem_addr,
   input  logic [IW-1:0]   imem_data,
   output logic [DW-1:0]   out_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [DW-1:0]   acc_o,
   output logic [PAW-1:0]  pc_o,
   output logic            carry_o,
   output logic            zero_o,
   output logic            halted
);

   stateT           state, stateNxt;
   logic [IW-1:0]   ir;
   logic [PAW-1:0]  pc;
   logic [DW-1:0]   acc, ramQ, outData, imm, aluB, aluRes;
   logic            carry, zero, outValid, aluCarry, aluZero;
   logic            memOp, immOp, takeJump, outFire, startOk;
   stateT           afterInstr;
   opcodeT          op;
   logic [AW-1:0]   ramAddr;
   logic [DW-1:0]   ram [2**AW];

   assign op      = opcodeT'(ir[IW-1:DW]);
   assign imm     = ir[DW-1:0];
   assign ramAddr = imm[AW-1:0];

   assign memOp    = (op == OP_LD)  || (op == OP_ADD) || (op == OP_SUB) ||
                     (op == OP_AND) || (op == OP_OR)  || (op == OP_XOR);
   assign immOp    = (op == OP_LDI) || (op == OP_ADDI) || (op == OP_SUBI);
   assign takeJump = (op == OP_JMP) || ((op == OP_JZ) && zero) ||
                     ((op == OP_JC) && carry);
   assign outFire  = (state == ST_OUTW) && outValid && out_ready;
   assign aluB     = (state == ST_MEMRD) ? ramQ : imm;

`ifdef ACC_CPU_SINGLE_STEP_EN
   assign startOk    = run && step;
   assign afterInstr = ST_IDLE;
`else
   assign startOk    = run;
   assign afterInstr = run ? ST_FETCH : ST_IDLE;
`endif

   acc_cpu_alu #(.DW(DW)) uAlu (
      .opcode   (op),
      .a        (acc),
      .b        (aluB),
      .carryIn  (carry),
      .result   (aluRes),
      .carryOut (aluCarry),
      .zero     (aluZero)
   );

   always_comb begin
      stateNxt = state;
      case (state)
         ST_IDLE:  if (startOk) stateNxt = ST_FETCH;
         ST_FETCH: stateNxt = ST_EXEC;
         ST_EXEC: begin
            if (memOp)              stateNxt = ST_MEMRD;
            else if (op == OP_OUT)  stateNxt = ST_OUTW;
            else if (op == OP_HLT)  stateNxt = ST_HALT;
            else                    stateNxt = afterInstr;
         end
         ST_MEMRD: stateNxt = afterInstr;
         ST_OUTW:  if (outFire) stateNxt = afterInstr;
         ST_HALT:  stateNxt = ST_HALT;
         default:  stateNxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         ir       <= '0;
         pc       <= '0;
         acc      <= '0;
         carry    <= 1'b0;
         zero     <= 1'b0;
         outData  <= '0;
         outValid <= 1'b0;
      end else begin
         state <= stateNxt;
         case (state)
            ST_FETCH: begin
               ir <= imem_data;
               pc <= pc + PAW'(1);
            end
            ST_EXEC: begin
               if (immOp) begin
                  acc   <= aluRes;
                  carry <= aluCarry;
                  zero  <= aluZero;
               end
               // overrides the increment already applied in FETCH
               if (takeJump) pc <= imm[PAW-1:0];
               if (op == OP_OUT) begin
                  outData  <= acc;
                  outValid <= 1'b1;
               end
            end
            ST_MEMRD: begin
               acc   <= aluRes;
               carry <= aluCarry;
               zero  <= aluZero;
            end
            ST_OUTW: if (outFire) outValid <= 1'b0;
            default: ;
         endcase
      end
   end

   // No reset on the array. Reset forces state out of EXEC asynchronously,
   // so an instruction aborted by reset never reaches the write enable.
   always_ff @(posedge clk) begin
      if (state == ST_EXEC) begin
         if (op == OP_ST) ram[ramAddr] <= acc;
         ramQ <= ram[ramAddr];
      end
   end

   assign imem_addr = pc;
   assign pc_o      = pc;
   assign acc_o     = acc;
   assign carry_o   = carry;
   assign zero_o    = zero;
   assign out_data  = outData;
   assign out_valid = outValid;
   assign halted    = (state == ST_HALT);

endmodule
